// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and imem write-port handshake for instr_encoder
// Ports: in_valid/in_ready/in_last plus opcode, rs, rt, rd, func and address on the input side;
// out_valid/out_ready/out_word/out_addr on the imem side. slave = encoder, master = environment.
interface instr_encoder_if #(parameter int ADDR_W = 8);
  logic in_valid, in_ready, in_last;
  logic [5:0] opcode;
  logic [4:0] rs, rt, rd;
  logic [5:0] func;
  logic [15:0] address;
  logic out_valid, out_ready;
  logic [31:0] out_word;
  logic [ADDR_W-1:0] out_addr;
  modport master (
    output in_valid, in_last, opcode, rs, rt, rd, func, address, out_ready,
    input in_ready, out_valid, out_word, out_addr
  );
  modport slave (
    input in_valid, in_last, opcode, rs, rt, rd, func, address, out_ready,
    output in_ready, out_valid, out_word, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS-style fields into 32-bit words and streams them to imem at sequential addresses
// Ports: clk, rst_n (async active-low), start (session pulse), bus (instr_encoder_if.slave),
// count (words delivered this session), busy (STREAM/FLUSH), done (session complete), wrap_err (pointer wrapped).
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              wrap_err
);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [31:0] enc;
  logic acc_in, acc_out, start_ok;
  assign enc = bus.opcode == 6'd0 ? {bus.opcode, bus.rs, bus.rt, bus.rd, 5'd0, bus.func}
                                  : {bus.opcode, bus.rs, bus.rt, bus.address};
  // The output register can take a new word when empty or being drained this cycle.
  assign bus.in_ready = state == STREAM && (!bus.out_valid || bus.out_ready);
  assign acc_in = bus.in_valid && bus.in_ready;
  assign acc_out = bus.out_valid && bus.out_ready;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign busy = state == STREAM || state == FLUSH;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? STREAM : state;
      STREAM: state_nx = acc_in && bus.in_last ? FLUSH : STREAM;
      FLUSH: state_nx = acc_out ? DONE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_word <= '0;
      bus.out_addr <= '0;
      ptr <= '0;
      count <= '0;
      wrap_err <= 1'b0;
    end else begin
      if (acc_in) begin
        bus.out_valid <= 1'b1;
        bus.out_word <= enc;
        bus.out_addr <= ptr;
      end else if (acc_out) bus.out_valid <= 1'b0;
      if (start_ok) begin
        ptr <= BASE_ADDR;
        count <= '0;
        wrap_err <= 1'b0;
      end else begin
        if (acc_in) ptr <= ptr + ADDR_W'(1);
        if (acc_in && &ptr) wrap_err <= 1'b1;
        if (acc_out) count <= count + (ADDR_W+1)'(1);
      end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench driving three lockstep encoders (W=8/B=0, W=8/B=0x10, W=2/B=3)
module tb_instr_encoder;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [5:0] opcode = '0, func = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [15:0] address = '0;
  logic [8:0] count0, count1;
  logic [2:0] count2, busy, done, wrap;
  int passed = 0, total = 0, idx = 0, cyc = 0;
  typedef struct {logic [31:0] w; int i;} exp_t;
  exp_t sb[$];

  instr_encoder_if #(8) b0();
  instr_encoder_if #(8) b1();
  instr_encoder_if #(2) b2();
  assign {b0.in_valid, b0.in_last, b0.out_ready} = {in_valid, in_last, out_ready};
  assign {b1.in_valid, b1.in_last, b1.out_ready} = {in_valid, in_last, out_ready};
  assign {b2.in_valid, b2.in_last, b2.out_ready} = {in_valid, in_last, out_ready};
  assign {b0.opcode, b0.rs, b0.rt, b0.rd, b0.func, b0.address} = {opcode, rs, rt, rd, func, address};
  assign {b1.opcode, b1.rs, b1.rt, b1.rd, b1.func, b1.address} = {opcode, rs, rt, rd, func, address};
  assign {b2.opcode, b2.rs, b2.rt, b2.rd, b2.func, b2.address} = {opcode, rs, rt, rd, func, address};

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h00)) u0 (.clk(clk), .rst_n(rst_n), .start(start), .bus(b0),
    .count(count0), .busy(busy[0]), .done(done[0]), .wrap_err(wrap[0]));
  instr_encoder #(.ADDR_W(8), .BASE_ADDR(8'h10)) u1 (.clk(clk), .rst_n(rst_n), .start(start), .bus(b1),
    .count(count1), .busy(busy[1]), .done(done[1]), .wrap_err(wrap[1]));
  instr_encoder #(.ADDR_W(2), .BASE_ADDR(2'd3)) u2 (.clk(clk), .rst_n(rst_n), .start(start), .bus(b2),
    .count(count2), .busy(busy[2]), .done(done[2]), .wrap_err(wrap[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] s, t, d,
                                      input logic [5:0] fn, input logic [15:0] a);
    return op == 6'd0 ? {op, s, t, d, 5'd0, fn} : {op, s, t, a};
  endfunction

  // Output-side scoreboard: every word written to imem must be the next expected one, at its expected address.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && b0.out_valid && b0.out_ready) begin
      total++;
      if (sb.size() == 0) $display("FAIL sb_empty: got word %h, expected no word", b0.out_word);
      else begin
        e = sb.pop_front();
        if (b0.out_word !== e.w || b1.out_word !== e.w || b2.out_word !== e.w)
          $display("FAIL sb_word: got %h/%h/%h expected %h", b0.out_word, b1.out_word, b2.out_word, e.w);
        else if (b0.out_addr !== 8'(e.i) || b1.out_addr !== 8'(8'h10 + e.i) || b2.out_addr !== 2'(3 + e.i))
          $display("FAIL sb_addr: got %h/%h/%h expected %h/%h/%h", b0.out_addr, b1.out_addr, b2.out_addr,
                   8'(e.i), 8'(8'h10 + e.i), 2'(3 + e.i));
        else passed++;
      end
    end
  end

  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    idx = 0;
  endtask

  task automatic send(input logic [5:0] op, input logic [4:0] s, t, d, input logic [5:0] fn,
                      input logic [15:0] a, input logic last);
    int k = 0;
    {opcode, rs, rt, rd, func, address, in_last} = {op, s, t, d, fn, a, last};
    in_valid = 1'b1;
    @(negedge clk);
    while (!b0.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!b0.in_ready) $display("FAIL send_timeout: in_ready=%b, required 1", b0.in_ready);
    else begin
      passed++;
      sb.push_back('{enc(op, s, t, d, fn, a), idx});
      idx++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic finish_session(input int n);
    int k = 0;
    while (done !== 3'b111 && k < 20) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (done !== 3'b111) $display("FAIL done_timeout: done=%b, required 111", done);
    else passed++;
    total++;
    if (count0 !== 9'(n) || count1 !== 9'(n) || count2 !== 3'(n))
      $display("FAIL session_count: got %0d/%0d/%0d required %0d", count0, count1, count2, n);
    else passed++;
    total++;
    if (busy !== 3'b000 || b0.out_valid !== 1'b0 || b0.in_ready !== 1'b0)
      $display("FAIL done_state: busy=%b out_valid=%b in_ready=%b, required 000/0/0", busy, b0.out_valid, b0.in_ready);
    else passed++;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (b0.out_valid !== 0 || b0.in_ready !== 0 || b0.out_word !== 0 || b0.out_addr !== 0 ||
        count0 !== 0 || busy !== 0 || done !== 0 || wrap !== 0)
      $display("FAIL reset_values: ov=%b ir=%b w=%h a=%h cnt=%0d busy=%b done=%b wrap=%b, required all 0",
               b0.out_valid, b0.in_ready, b0.out_word, b0.out_addr, count0, busy, done, wrap);
    else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (b0.in_ready !== 0 || busy !== 0 || b0.out_valid !== 0)
      $display("FAIL idle_ignore: in_ready=%b busy=%b out_valid=%b, required 0/000/0", b0.in_ready, busy, b0.out_valid);
    else passed++;
    in_valid = 1'b0;
  endtask

  task automatic test_rtype;
    pulse_start;
    send(6'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'hBEEF, 1'b1);
    total++;
    if (b0.out_word !== 32'h00221820 || b0.out_addr !== 8'h00 || b0.out_valid !== 1'b1)
      $display("FAIL rtype_word: got %h@%h v=%b, required 00221820@00 v=1", b0.out_word, b0.out_addr, b0.out_valid);
    else passed++;
    finish_session(1);
  endtask

  task automatic test_itype;
    pulse_start;
    send(6'h23, 5'd5, 5'd8, 5'd31, 6'd63, 16'hFFFC, 1'b1);
    total++;
    if (b0.out_word !== 32'h8CA8FFFC) $display("FAIL itype_word: got %h, required 8ca8fffc", b0.out_word);
    else passed++;
    finish_session(1);
  endtask

  task automatic test_back_to_back;
    int c0;
    pulse_start;
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      send(i == 2 ? 6'd0 : 6'(6'h08 + i), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 16'($urandom), i == 3);
      total++;
      if (b1.out_addr !== 8'(8'h10 + i) || b1.out_valid !== 1'b1)
        $display("FAIL b2b_addr%0d: got %h v=%b, required %h v=1", i, b1.out_addr, b1.out_valid, 8'(8'h10 + i));
      else passed++;
    end
    total++;
    if (cyc - c0 !== 4) $display("FAIL b2b_throughput: took %0d cycles, required 4", cyc - c0);
    else passed++;
    finish_session(4);
  endtask

  task automatic test_stall;
    pulse_start;
    out_ready = 1'b0;
    send(6'h08, 5'd1, 5'd2, 5'd0, 6'd0, 16'h1234, 1'b0);
    {opcode, rs, rt, rd, func, address} = {6'd0, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h0};
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start = k == 0;
      @(negedge clk);
      total++;
      if (b0.in_ready !== 0 || b0.out_valid !== 1 || b0.out_word !== 32'h20221234 || b1.out_addr !== 8'h10)
        $display("FAIL stall_hold%0d: ir=%b ov=%b w=%h a=%h, required 0/1/20221234/10",
                 k, b0.in_ready, b0.out_valid, b0.out_word, b1.out_addr);
      else passed++;
      @(posedge clk);
      #1 start = 1'b0;
    end
    out_ready = 1'b1;
    send(6'd0, 5'd4, 5'd5, 5'd6, 6'h2A, 16'h0, 1'b1);
    total++;
    if (b0.out_word !== 32'h0085302A || b1.out_addr !== 8'h11)
      $display("FAIL stall_next: got %h@%h, required 0085302a@11", b0.out_word, b1.out_addr);
    else passed++;
    finish_session(2);
  endtask

  task automatic test_wrap;
    pulse_start;
    total++;
    if (wrap !== 3'b000) $display("FAIL wrap_clear: wrap_err=%b, required 000", wrap);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      send(6'h0D, 5'(i), 5'(i + 1), 5'd0, 6'd0, 16'(16'hA000 + i), i == 2);
      total++;
      if (b2.out_addr !== 2'(3 + i)) $display("FAIL wrap_addr%0d: got %0d, required %0d", i, b2.out_addr, 2'(3 + i));
      else passed++;
      if (i == 1) begin
        total++;
        if (wrap !== 3'b100) $display("FAIL wrap_flag: wrap_err=%b, required 100", wrap);
        else passed++;
      end
    end
    finish_session(3);
  endtask

  task automatic test_reset_mid;
    pulse_start;
    out_ready = 1'b0;
    send(6'h2B, 5'd3, 5'd7, 5'd0, 6'd0, 16'h0040, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (b0.out_valid !== 0 || b1.out_valid !== 0 || b2.out_valid !== 0 || busy !== 0 || count0 !== 0)
      $display("FAIL async_reset: ov=%b%b%b busy=%b cnt=%0d, required 000/000/0",
               b0.out_valid, b1.out_valid, b2.out_valid, busy, count0);
    else passed++;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    pulse_start;
    total++;
    if (busy !== 3'b111 || count0 !== 0 || count1 !== 0)
      $display("FAIL restart: busy=%b count=%0d/%0d, required 111/0/0", busy, count0, count1);
    else passed++;
    send(6'h2B, 5'd3, 5'd7, 5'd0, 6'd0, 16'h0044, 1'b1);
    total++;
    if (b1.out_addr !== 8'h10 || b2.out_addr !== 2'd3)
      $display("FAIL restart_addr: got %h/%0d, required 10/3", b1.out_addr, b2.out_addr);
    else passed++;
    finish_session(1);
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_itype;
    test_back_to_back;
    test_stall;
    test_wrap;
    test_reset_mid;
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: %0d words undelivered, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
